// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier:
//   state_t   - controller states IDLE / CALC / DONE
//   SEL_*     - magnitude select of a recoded digit (0, M, 2M)
//   recode_t  - recoder output {neg, sel}; neg flags a subtracted partial product
//   clog2     - ceiling log2, used to size the iteration counter
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SEL_ZERO = 2'd0;
    localparam logic [1:0] SEL_M    = 2'd1;
    localparam logic [1:0] SEL_2M   = 2'd2;

    typedef struct packed {
        logic       neg;
        logic [1:0] sel;
    } recode_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth digit recoder (combinational).
//   bits : {Q[1], Q[0], Qm1} window of the multiplier shift register
//   rc   : {neg, sel} - digit is (neg ? -1 : +1) * {0, M, 2M}[sel]
module booth_r4_recoder
    import booth_pkg::*;
(
    input  logic [2:0] bits,
    output recode_t    rc
);

    always_comb begin
        rc.neg = 1'b0;
        rc.sel = SEL_ZERO;
        case (bits)
            3'b001, 3'b010: rc.sel = SEL_M;
            3'b011:         rc.sel = SEL_2M;
            3'b100: begin
                rc.neg = 1'b1;
                rc.sel = SEL_2M;
            end
            3'b101, 3'b110: begin
                rc.neg = 1'b1;
                rc.sel = SEL_M;
            end
            default: ; // 000 / 111: zero digit
        endcase
    end

endmodule

// File: rtl/booth_r4_mult_seq.sv
// Sequential radix-4 Booth multiplier with integrated controller.
// One radix-4 digit per clock; add and 2-bit arithmetic shift in the same edge.
//   clk, rst_b    : clock, asynchronous active-low reset
//   start         : request, sampled in IDLE or DONE
//   signed_mode   : 1 = two's-complement operands, 0 = unsigned
//   multiplicand  : operand M (WIDTH bits)
//   multiplier    : operand Q (WIDTH bits)
//   busy          : high while computing
//   done          : one-cycle completion pulse
//   product       : 2*WIDTH-bit result, held until the next completion
module booth_r4_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int N_IT = WIDTH / 2 + 1;
    localparam int EW   = WIDTH + 2;   // extended operand width
    localparam int AW   = WIDTH + 4;   // accumulator: room for +/-2M without overflow
    localparam int CW   = clog2(N_IT);
    localparam logic [CW-1:0] LAST = CW'(N_IT - 1);

    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("booth_r4_mult_seq: WIDTH must be even and >= 4");
    end

    state_t         state;
    logic [AW-1:0]  acc;
    logic [EW-1:0]  mcand;
    logic [EW-1:0]  q;
    logic           qm1;
    logic [CW-1:0]  cnt;

    // Two extra bits so unsigned operands look positive to the signed datapath;
    // the extra multiplier bits also give the final digit that unsigned needs.
    logic [EW-1:0]  mc_ext, mp_ext;
    assign mc_ext = {{2{signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
    assign mp_ext = {{2{signed_mode & multiplier[WIDTH-1]}}, multiplier};

    recode_t rc;
    booth_r4_recoder u_recoder (
        .bits ({q[1:0], qm1}),
        .rc   (rc)
    );

    logic [AW-1:0]      m_full, pp, addend, sum, acc_nxt;
    logic [EW-1:0]      q_nxt;
    logic [2*WIDTH-1:0] prod_nxt;

    always_comb begin
        m_full = {{2{mcand[EW-1]}}, mcand};
        case (rc.sel)
            SEL_M:   pp = m_full;
            SEL_2M:  pp = {m_full[AW-2:0], 1'b0};
            default: pp = '0;
        endcase
        // Subtract as invert + carry-in so one adder serves both signs.
        addend   = rc.neg ? ~pp : pp;
        sum      = acc + addend + {{(AW-1){1'b0}}, rc.neg};
        acc_nxt  = {{2{sum[AW-1]}}, sum[AW-1:2]};
        q_nxt    = {sum[1:0], q[EW-1:2]};
        prod_nxt = {acc_nxt[WIDTH-3:0], q_nxt};
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            mcand   <= '0;
            q       <= '0;
            qm1     <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= mc_ext;
                        q     <= mp_ext;
                        qm1   <= 1'b0;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    q   <= q_nxt;
                    qm1 <= q[1];
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        product <= prod_nxt;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_mult_seq.sv
// Scoreboard bench for booth_r4_mult_seq at WIDTH=8 (directed timing and
// corner cases), WIDTH=16 and WIDTH=4 (corners plus random pairs).
module tb_booth_r4_mult_seq;

    localparam int N8  = 5;
    localparam int N16 = 9;
    localparam int N4  = 3;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  mc8, mp8;
    logic [15:0] product8;
    logic        start16, sm16, busy16, done16;
    logic [15:0] mc16, mp16;
    logic [31:0] product16;
    logic        start4, sm4, busy4, done4;
    logic [3:0]  mc4, mp4;
    logic [7:0]  product4;

    booth_r4_mult_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst_b(rst_b), .start(start8), .signed_mode(sm8),
        .multiplicand(mc8), .multiplier(mp8), .busy(busy8), .done(done8), .product(product8));
    booth_r4_mult_seq #(.WIDTH(16)) u16 (
        .clk(clk), .rst_b(rst_b), .start(start16), .signed_mode(sm16),
        .multiplicand(mc16), .multiplier(mp16), .busy(busy16), .done(done16), .product(product16));
    booth_r4_mult_seq #(.WIDTH(4)) u4 (
        .clk(clk), .rst_b(rst_b), .start(start4), .signed_mode(sm4),
        .multiplicand(mc4), .multiplier(mp4), .busy(busy4), .done(done4), .product(product4));

    int checks = 0;
    int errors = 0;
    logic [63:0] sb8[$], sb16[$], sb4[$];
    logic [15:0] last8 = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference product: exact integer multiply of the interpreted operands.
    function automatic logic [63:0] ref_mul(input logic sm, input logic [15:0] m, input logic [15:0] q,
                                            input int w);
        longint a, b;
        logic [63:0] mask;
        a = longint'(m);
        b = longint'(q);
        if (sm && m[w-1]) a = a - (longint'(1) << w);
        if (sm && q[w-1]) b = b - (longint'(1) << w);
        mask = (64'd1 << (2 * w)) - 64'd1;
        return 64'(a * b) & mask;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Output-side scoreboards: pop on every completion pulse.
    always @(negedge clk) begin
        if (done8) begin
            if (sb8.size() == 0) chk("sb8_unexpected_done", 1, 0);
            else chk("prod8", 64'(product8), sb8.pop_front());
        end
        if (done16) begin
            if (sb16.size() == 0) chk("sb16_unexpected_done", 1, 0);
            else chk("prod16", 64'(product16), sb16.pop_front());
        end
        if (done4) begin
            if (sb4.size() == 0) chk("sb4_unexpected_done", 1, 0);
            else chk("prod4", 64'(product4), sb4.pop_front());
        end
    end

    // WIDTH=8 op with cycle-exact busy/done checks; returns at the DONE negedge
    // with start8 low, so a following call runs back-to-back.
    task automatic op8(input logic sm, input logic [7:0] m, input logic [7:0] q,
                       input logic [15:0] exp, input bit pulse);
        start8 = 1'b1; sm8 = sm; mc8 = m; mp8 = q;
        sb8.push_back(64'(exp));
        step();
        start8 = 1'b0; sm8 = ~sm; mc8 = ~m; mp8 = ~q;
        chk("busy8", {busy8, done8}, 2'b10);
        chk("hold8", product8, last8);
        for (int i = 1; i < N8; i++) begin
            if (pulse) start8 = i[0];
            step();
            chk("busy8", {busy8, done8}, 2'b10);
            chk("hold8", product8, last8);
        end
        start8 = 1'b0;
        step();
        chk("done8", {busy8, done8}, 2'b01);
        last8 = exp;
    endtask

    task automatic op16(input logic sm, input logic [15:0] m, input logic [15:0] q);
        int lat;
        start16 = 1'b1; sm16 = sm; mc16 = m; mp16 = q;
        sb16.push_back(ref_mul(sm, m, q, 16));
        step();
        start16 = 1'b0; mc16 = 16'($urandom); mp16 = 16'($urandom);
        lat = 0;
        while (!done16 && lat < 40) begin
            step();
            lat++;
        end
        chk("lat16", lat, N16);
        step();
    endtask

    task automatic op4(input logic sm, input logic [3:0] m, input logic [3:0] q);
        int lat;
        start4 = 1'b1; sm4 = sm; mc4 = m; mp4 = q;
        sb4.push_back(ref_mul(sm, 16'(m), 16'(q), 4));
        step();
        start4 = 1'b0; mc4 = 4'($urandom); mp4 = 4'($urandom);
        lat = 0;
        while (!done4 && lat < 40) begin
            step();
            lat++;
        end
        chk("lat4", lat, N4);
        step();
    endtask

    initial begin
        logic [7:0] r8a, r8b;
        logic       rs;
        rst_b = 1'b0;
        start8 = 0;  sm8 = 0;  mc8 = '0;  mp8 = '0;
        start16 = 0; sm16 = 0; mc16 = '0; mp16 = '0;
        start4 = 0;  sm4 = 0;  mc4 = '0;  mp4 = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst8_flags", {busy8, done8}, 2'b00);
        chk("rst8_prod", product8, 16'h0000);
        chk("rst16_prod", product16, 32'h0);
        chk("rst4_prod", product4, 8'h00);
        rst_b = 1'b1;
        step();

        // Directed WIDTH=8 corners.
        op8(1'b1, 8'h80, 8'h80, 16'h4000, 1'b0);
        step(); chk("idle8", {busy8, done8}, 2'b00);
        op8(1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0);
        step(); chk("idle8", {busy8, done8}, 2'b00);
        op8(1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b0);
        step();
        op8(1'b1, 8'h80, 8'h7F, 16'hC080, 1'b0);
        step();
        op8(1'b0, 8'hFF, 8'h80, 16'h7F80, 1'b0);
        step();
        op8(1'b1, 8'h00, 8'h5A, 16'h0000, 1'b0);
        step();

        // Back-to-back chain with start pulses during CALC.
        op8(1'b1, 8'h7F, 8'h7F, 16'h3F01, 1'b1);
        op8(1'b1, 8'hFD, 8'h09, 16'hFFE5, 1'b1);
        op8(1'b0, 8'h0C, 8'hC8, 16'h0960, 1'b0);
        step(); chk("idle8", {busy8, done8}, 2'b00);

        // Asynchronous reset during the third CALC edge.
        start8 = 1'b1; sm8 = 1'b0; mc8 = 8'h33; mp8 = 8'h44;
        sb8.push_back(ref_mul(1'b0, 16'h33, 16'h44, 8));
        step();
        start8 = 1'b0;
        step();
        step();
        rst_b = 1'b0;
        #1;
        chk("arst8_flags", {busy8, done8}, 2'b00);
        chk("arst8_prod", product8, 16'h0000);
        void'(sb8.pop_back());
        last8 = '0;
        @(negedge clk);
        rst_b = 1'b1;
        step();
        op8(1'b0, 8'h33, 8'h44, 16'h0D8C, 1'b0);
        step();

        for (int i = 0; i < 20; i++) begin
            r8a = 8'($urandom); r8b = 8'($urandom); rs = 1'($urandom);
            op8(rs, r8a, r8b, 16'(ref_mul(rs, 16'(r8a), 16'(r8b), 8)), 1'b0);
            step();
        end

        // WIDTH=16 and WIDTH=4 corners then random pairs.
        op16(1'b1, 16'h8000, 16'h8000);
        op16(1'b0, 16'hFFFF, 16'hFFFF);
        op16(1'b1, 16'h8000, 16'h7FFF);
        op4(1'b1, 4'h8, 4'h8);
        op4(1'b0, 4'hF, 4'hF);
        op4(1'b1, 4'h8, 4'h7);
        for (int i = 0; i < 2000; i++)
            op16(1'($urandom), 16'($urandom), 16'($urandom));
        for (int i = 0; i < 2000; i++)
            op4(1'($urandom), 4'($urandom), 4'($urandom));

        step();
        chk("sb_drained", sb8.size() + sb16.size() + sb4.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
